aes128_stream_core: RTL and testbench

- Iterative AES-128 core that supports both encryption and decryption, selected per block by a mode bit.
- Blocks enter and leave over valid/ready streams. An input FIFO decouples the bus side, and the output register lets the next block start while the last result is still waiting to be taken.
- The expanded key is held in registers and reused across blocks until a new key is loaded.
- Sits behind the Avalon register interface as the next-generation replacement for the single-shot decrypt-only core.

---
 rtl/aes_pkg.sv | 86 ++++++++
 rtl/aes_round.sv | 32 +++
 rtl/aes128_stream_core.sv | 177 +++++++++++++++++
 tb/tb_aes128_stream_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 constants and GF(2^8) helpers shared by the stream core and its round datapath.
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef enum logic {AES_ENC = 1'b0, AES_DEC = 1'b1} aes_mode_e;
  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_LOAD, S_ROUND, S_HOLD} aes_fsm_e;

  // Entry i lives at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // RCON[1] is the top byte.
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return RCON[8*(10-int'(i)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3,
            a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3,
            a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3),
            gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0,14) ^ gmul(a1,11) ^ gmul(a2,13) ^ gmul(a3,9),
            gmul(a0,9)  ^ gmul(a1,14) ^ gmul(a2,11) ^ gmul(a3,13),
            gmul(a0,13) ^ gmul(a1,9)  ^ gmul(a2,14) ^ gmul(a3,11),
            gmul(a0,11) ^ gmul(a1,13) ^ gmul(a2,9)  ^ gmul(a3,14)};
  endfunction

  function automatic aes_state_t key_expand(input aes_state_t prev, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(i), 24'h0};
    w0 ^= t;
    w1 ^= w0;
    w2 ^= w1;
    w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_round.sv
// One AES round, encrypt or decrypt; optionally registers the (Inv)SubBytes output.
module aes_round import aes_pkg::*; #(
  parameter int ROUND_REG = 0
) (
  input  logic       CLK,
  input  aes_state_t st_in,
  input  aes_state_t rk,
  input  aes_mode_e  mode,
  input  logic       last,
  output aes_state_t st_out
);
  aes_state_t sb_c, mid_q, mid, ark;

  // ShiftRows commutes with SubBytes, so both directions share one byte-permute+lookup stage.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int K  = r + 4*c;
      localparam int KE = r + 4*((c + r) % 4);
      localparam int KD = r + 4*((c - r + 4) % 4);
      assign sb_c[127-8*K -: 8] = (mode == AES_DEC) ? inv_sbox(st_in[127-8*KD -: 8])
                                                   : sbox(st_in[127-8*KE -: 8]);
    end
    assign st_out[127-32*c -: 32] = last ? ark[127-32*c -: 32] :
      (mode == AES_DEC) ? inv_mix_col(ark[127-32*c -: 32])
                        : (mix_col(mid[127-32*c -: 32]) ^ rk[127-32*c -: 32]);
  end

  always_ff @(posedge CLK) mid_q <= sb_c;

  assign mid = (ROUND_REG != 0) ? mid_q : sb_c;
  assign ark = mid ^ rk;
endmodule

// File: rtl/aes128_stream_core.sv
// Iterative AES-128 enc/dec core: input FIFO, stored key schedule, one round per step.
module aes128_stream_core import aes_pkg::*; #(
  parameter int IN_DEPTH  = 2,
  parameter int ROUND_REG = 0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         key_load,
  input  logic [127:0] key,
  output logic         key_ready,
  output logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [127:0] out_data
);
  localparam int AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int CW = $clog2(IN_DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(IN_DEPTH - 1);

  aes_fsm_e   state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       ph_q, ph_d;
  aes_state_t st_q, st_d, rnd_out, rk_sel;
  aes_mode_e  mode_q, mode_d;
  aes_state_t rk_q [11];
  aes_state_t rk_d [11];
  logic       key_valid_q, key_valid_d, out_valid_q, out_valid_d, out_mode_q, out_mode_d;
  aes_state_t out_data_q, out_data_d;

  logic [128:0]  fifo_q [IN_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, empty, full, round_end, can_out;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(IN_DEPTH));
  assign push      = in_valid && !full;
  assign pop       = (state_q == S_LOAD);
  assign round_end = (ROUND_REG == 0) || ph_q;
  assign can_out   = !out_valid_q || out_ready;

  always_ff @(posedge CLK) if (push) fifo_q[wp_q] <= {in_mode, in_data};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= (wp_q == LAST_PTR) ? '0 : wp_q + 1'b1;
      if (pop)  rp_q <= (rp_q == LAST_PTR) ? '0 : rp_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rk_sel = rk_q[(mode_q == AES_DEC) ? 4'(4'd10 - rnd_q) : rnd_q];

  aes_round #(.ROUND_REG(ROUND_REG)) u_round (
    .CLK    (CLK),
    .st_in  (st_q),
    .rk     (rk_sel),
    .mode   (mode_q),
    .last   (rnd_q == 4'd10),
    .st_out (rnd_out)
  );

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    ph_d        = ph_q;
    st_d        = st_q;
    mode_d      = mode_q;
    rk_d        = rk_q;
    key_valid_d = key_valid_q;
    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_load && empty) begin
          rk_d[0]     = key;
          key_valid_d = 1'b0;
          rnd_d       = 4'd1;
          state_d     = S_KEXP;
        end else if (!empty && key_valid_q) begin
          state_d = S_LOAD;
        end
      end
      S_KEXP: begin
        rk_d[rnd_q] = key_expand(rk_q[4'(rnd_q - 4'd1)], rnd_q);
        if (rnd_q == 4'd10) begin
          key_valid_d = 1'b1;
          rnd_d       = '0;
          state_d     = S_IDLE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_LOAD: begin
        mode_d  = aes_mode_e'(fifo_q[rp_q][128]);
        st_d    = fifo_q[rp_q][127:0] ^ ((mode_d == AES_DEC) ? rk_q[10] : rk_q[0]);
        rnd_d   = 4'd1;
        ph_d    = 1'b0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (ROUND_REG != 0) ph_d = !ph_q;
        if (round_end) begin
          st_d = rnd_out;
          if (rnd_q == 4'd10) begin
            rnd_d = '0;
            if (can_out) begin
              out_data_d  = rnd_out;
              out_mode_d  = mode_q;
              out_valid_d = 1'b1;
              state_d     = empty ? S_IDLE : S_LOAD;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        // Finished result parks in st_q until the output register frees up.
        if (can_out) begin
          out_data_d  = st_q;
          out_mode_d  = mode_q;
          out_valid_d = 1'b1;
          state_d     = empty ? S_IDLE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      rnd_q       <= '0;
      ph_q        <= 1'b0;
      st_q        <= '0;
      mode_q      <= AES_ENC;
      key_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      ph_q        <= ph_d;
      st_q        <= st_d;
      mode_q      <= mode_d;
      key_valid_q <= key_valid_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      out_data_q  <= out_data_d;
      rk_q        <= rk_d;
    end
  end

  assign key_ready = (state_q == S_IDLE) && empty;
  assign key_valid = key_valid_q;
  assign in_ready  = !full;
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_aes128_stream_core.sv
// Scoreboard bench for aes128_stream_core using FIPS-197 known-answer vectors.
module tb_aes128_stream_core;
  import aes_pkg::*;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         CLK = 1'b0, RESET = 1'b1, key_load = 1'b0, in_valid = 1'b0, in_mode = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] key = '0, in_data = '0;
  logic         key_ready, key_valid, in_ready, out_valid, out_mode;
  logic [127:0] out_data;

  int           n_cmp = 0, n_err = 0;
  logic [128:0] sb [$];
  logic [128:0] mon_exp;
  logic         saw_full = 1'b0;

  aes128_stream_core #(.IN_DEPTH(2), .ROUND_REG(0)) dut (
    .CLK(CLK), .RESET(RESET), .key_load(key_load), .key(key),
    .key_ready(key_ready), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Handshake completes at the next posedge; compare while it is stable.
  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 129'(out_valid), 129'h0);
      else begin
        mon_exp = sb.pop_front();
        chk("out", {out_mode, out_data}, mon_exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic m, input logic [127:0] d, input logic [127:0] exp, input bit track);
    int t = 0;
    bit ok = 1'b1;
    in_valid = 1'b1; in_mode = m; in_data = d;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      saw_full = 1'b1;
      t++;
      if (t > 200) begin chk("push_timeout", 129'(in_ready), 129'h1); ok = 1'b0; break; end
      @(posedge CLK); #1;
    end
    if (ok && track) sb.push_back({m, exp});
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_key_ready();
    int t = 0;
    while (!key_ready && t < 300) begin cyc(1); t++; end
    if (t >= 300) chk("key_ready_timeout", 129'(key_ready), 129'h1);
  endtask

  task automatic load_key(input logic [127:0] k, output int lat);
    wait_key_ready();
    key = k; key_load = 1'b1;
    cyc(1);
    key_load = 1'b0;
    lat = 0;
    while (!key_valid && lat < 50) begin cyc(1); lat++; end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin cyc(1); t++; end
    chk("drain", 129'(sb.size()), 129'h0);
    cyc(2);
  endtask

  initial begin
    int lat, nchg, nout;
    logic [128:0] held;

    // Reset state
    cyc(3);
    RESET = 1'b0;
    chk("rst_key_ready", 129'(key_ready), 129'h1);
    chk("rst_in_ready",  129'(in_ready),  129'h1);
    chk("rst_out_valid", 129'(out_valid), 129'h0);
    chk("rst_key_valid", 129'(key_valid), 129'h0);
    chk("rst_out",       {out_mode, out_data}, 129'h0);

    // Block before any key: nothing comes out
    push(1'b0, PB, CB, 1'b0);
    cyc(25);
    chk("nokey_out_valid", 129'(out_valid), 129'h0);
    chk("nokey_key_ready", 129'(key_ready), 129'h0);
    RESET = 1'b1; cyc(1); RESET = 1'b0;
    chk("nokey_flush", 129'(key_ready), 129'h1);

    // FIPS-197 App. B encrypt with latency checks
    load_key(KB, lat);
    chk("kexp_lat", 129'(lat), 129'd10);
    push(1'b0, PB, CB, 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin cyc(1); lat++; end
    chk("enc_lat", 129'(lat), 129'd12);
    drain();

    // FIPS-197 C.1 decrypt
    load_key(KC, lat);
    push(1'b1, CC, PC, 1'b1);
    drain();

    // Mixed back-to-back stream
    saw_full = 1'b0;
    push(1'b0, PC, CC, 1'b1);
    push(1'b1, CC, PC, 1'b1);
    push(1'b0, PC, CC, 1'b1);
    chk("mix_in_ready_drop", 129'(saw_full), 129'h1);
    drain();

    // key_load while busy is ignored
    push(1'b0, PC, CC, 1'b1);
    cyc(3);
    key = KB; key_load = 1'b1;
    cyc(1);
    key_load = 1'b0;
    chk("busy_key_valid", 129'(key_valid), 129'h1);
    drain();

    // Backpressure
    out_ready = 1'b0;
    saw_full = 1'b0;
    push(1'b0, PC, CC, 1'b1);
    push(1'b1, CC, PC, 1'b1);
    push(1'b0, PC, CC, 1'b1);
    push(1'b1, CC, PC, 1'b1);
    cyc(1);
    held = {out_mode, out_data};
    nchg = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!out_valid || {out_mode, out_data} !== held) nchg++;
    end
    chk("bp_held",     held, {1'b0, CC});
    chk("bp_stable",   129'(nchg), 129'h0);
    chk("bp_state",    129'(dut.state_q), 129'(S_HOLD));
    chk("bp_in_ready", 129'(in_ready), 129'h0);
    chk("bp_saw_full", 129'(saw_full), 129'h1);
    out_ready = 1'b1;
    drain();

    // key_load in the same cycle as a push
    wait_key_ready();
    key = KB; key_load = 1'b1;
    in_valid = 1'b1; in_mode = 1'b0; in_data = PB;
    @(negedge CLK);
    chk("same_key_ready", 129'(key_ready), 129'h1);
    chk("same_in_ready",  129'(in_ready),  129'h1);
    sb.push_back({1'b0, CB});
    cyc(1);
    key_load = 1'b0; in_valid = 1'b0;
    drain();

    // Reset during round 5 with blocks queued
    push(1'b0, PB, CB, 1'b0);
    push(1'b0, PB, CB, 1'b0);
    push(1'b0, PB, CB, 1'b0);
    lat = 0;
    while (!(dut.state_q == S_ROUND && dut.rnd_q == 4'd5) && lat < 50) begin cyc(1); lat++; end
    chk("rst_reach_r5", 129'(dut.rnd_q), 129'd5);
    chk("rst_queued",   129'(dut.cnt_q), 129'd2);
    RESET = 1'b1; cyc(1); RESET = 1'b0;
    chk("mid_rst_out_valid", 129'(out_valid), 129'h0);
    chk("mid_rst_key_valid", 129'(key_valid), 129'h0);
    chk("mid_rst_key_ready", 129'(key_ready), 129'h1);
    chk("mid_rst_fifo",      129'(dut.cnt_q), 129'h0);
    nout = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (out_valid) nout++;
    end
    chk("mid_rst_quiet", 129'(nout), 129'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
